// File: rtl/echo_portal_pkg.sv
// Shared definitions for the Echo request portal: header field positions, method ids, FSM states.
package echo_portal_pkg;

    localparam logic [15:0] METHOD_SAY    = 16'd0;
    localparam logic [15:0] SAY_SIZE_BITS = 16'd32;

    localparam int HDR_METHOD_MSB = 31;
    localparam int HDR_METHOD_LSB = 16;
    localparam int HDR_LEN_MSB    = 15;
    localparam int HDR_LEN_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN
    } state_e;

endpackage

// File: rtl/echo_req_fifo.sv
// Small synchronous FIFO with a combinational head; shared by the request and indication portals.
module echo_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_enq;
    logic             do_deq;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;
    assign head   = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data array has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/echo_request_input.sv
// Request-portal stage for Echo: decodes framed host words, buffers say arguments and drives Echo.say.
module echo_request_input
    import echo_portal_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] SAY_METHOD = METHOD_SAY,
    parameter int          ERR_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      requests_0_enq_v,
    input  logic             EN_requests_0_enq,
    output logic             RDY_requests_0_enq,
    output logic [31:0]      request_say_v,
    output logic             EN_request_say,
    input  logic             RDY_request_say,
    input  logic [15:0]      messageSize_size_methodNumber,
    output logic [15:0]      messageSize_size,
    output logic             RDY_messageSize_size,
    output logic [ERR_W-1:0] err_count
);

    state_e      state;
    logic [15:0] rem;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic [15:0] hdr_method;
    logic [15:0] hdr_len;

    assign hdr_method = requests_0_enq_v[HDR_METHOD_MSB:HDR_METHOD_LSB];
    assign hdr_len    = requests_0_enq_v[HDR_LEN_MSB:HDR_LEN_LSB];

    assign RDY_requests_0_enq = !RST && ((state != PAYLOAD) || !fifo_full);
    assign accept             = EN_requests_0_enq && RDY_requests_0_enq;
    assign push               = accept && (state == PAYLOAD);
    assign EN_request_say     = !fifo_empty && RDY_request_say;

    assign messageSize_size     = (messageSize_size_methodNumber == SAY_METHOD) ? SAY_SIZE_BITS : 16'd0;
    assign RDY_messageSize_size = 1'b1;

    echo_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .enq      (push),
        .enq_data (requests_0_enq_v),
        .deq      (EN_request_say),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (request_say_v)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rem       <= '0;
            err_count <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (hdr_method == SAY_METHOD && hdr_len == 16'd2) begin
                        state <= PAYLOAD;
                    end else begin
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                        // Header-only frames carry nothing to discard.
                        if (hdr_len > 16'd1) begin
                            rem   <= hdr_len - 16'd1;
                            state <= DRAIN;
                        end
                    end
                end
                PAYLOAD: state <= IDLE;
                DRAIN: begin
                    rem <= rem - 16'd1;
                    if (rem == 16'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_enq_only_when_ready : assert property (@(posedge CLK) disable iff (RST)
        EN_requests_0_enq |-> RDY_requests_0_enq);

endmodule

// File: tb/tb_echo_request_input.sv
// Scoreboard bench for echo_request_input: directed frames, say values checked by an independent monitor.
module tb_echo_request_input;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] requests_0_enq_v = '0;
    logic        EN_requests_0_enq = 1'b0;
    logic        RDY_requests_0_enq;
    logic [31:0] request_say_v;
    logic        EN_request_say;
    logic        RDY_request_say = 1'b0;
    logic [15:0] messageSize_size_methodNumber = '0;
    logic [15:0] messageSize_size;
    logic        RDY_messageSize_size;
    logic [15:0] err_count;

    // Narrow-counter instance used only to reach saturation quickly.
    logic [31:0] sat_v  = '0;
    logic        sat_en = 1'b0;
    logic        sat_rdy;
    logic [31:0] sat_say_v;
    logic        sat_say_en;
    logic [15:0] sat_size;
    logic        sat_size_rdy;
    logic [2:0]  sat_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          run_len = 0;
    int          max_run = 0;

    always #5 CLK = ~CLK;

    echo_request_input dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .requests_0_enq_v              (requests_0_enq_v),
        .EN_requests_0_enq             (EN_requests_0_enq),
        .RDY_requests_0_enq            (RDY_requests_0_enq),
        .request_say_v                 (request_say_v),
        .EN_request_say                (EN_request_say),
        .RDY_request_say               (RDY_request_say),
        .messageSize_size_methodNumber (messageSize_size_methodNumber),
        .messageSize_size              (messageSize_size),
        .RDY_messageSize_size          (RDY_messageSize_size),
        .err_count                     (err_count)
    );

    echo_request_input #(.ERR_W(3)) dut_sat (
        .CLK                           (CLK),
        .RST                           (RST),
        .requests_0_enq_v              (sat_v),
        .EN_requests_0_enq             (sat_en),
        .RDY_requests_0_enq            (sat_rdy),
        .request_say_v                 (sat_say_v),
        .EN_request_say                (sat_say_en),
        .RDY_request_say               (1'b1),
        .messageSize_size_methodNumber (16'd0),
        .messageSize_size              (sat_size),
        .RDY_messageSize_size          (sat_size_rdy),
        .err_count                     (sat_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every fired say must match the oldest expected argument.
    always @(negedge CLK) begin
        if (EN_request_say) begin
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL say_unexpected: got 0x%08h expected no say", request_say_v);
            end else begin
                check("say_value", request_say_v, exp_q.pop_front());
            end
        end else begin
            run_len = 0;
        end
    end

    // Callers sit just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] w);
        int n = 0;
        while (!RDY_requests_0_enq && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!RDY_requests_0_enq) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got RDY=0 expected RDY=1 for word 0x%08h", w);
        end else begin
            requests_0_enq_v  = w;
            EN_requests_0_enq = 1'b1;
            @(posedge CLK);
            #1;
            EN_requests_0_enq = 1'b0;
            requests_0_enq_v  = '0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        check("rdy_in_reset", 32'(RDY_requests_0_enq), 32'd0);
        RST = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #1;
        do_reset();
        @(negedge CLK);
        check("rst_rdy_after", 32'(RDY_requests_0_enq), 32'd1);
        check("rst_en_say", 32'(EN_request_say), 32'd0);
        check("rst_say_v", request_say_v, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        @(posedge CLK);
        #1;

        // 1: single say, fires the cycle after the payload edge
        RDY_request_say = 1'b1;
        send(32'h0000_0002);
        exp_q.push_back(32'hDEAD_BEEF);
        send(32'hDEAD_BEEF);
        @(negedge CLK);
        check("t1_latency_en", 32'(EN_request_say), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        idle(2);

        // 2: back-pressure fills the buffer, third payload stalls
        RDY_request_say = 1'b0;
        send(32'h0000_0002);
        exp_q.push_back(32'h1111_0001);
        send(32'h1111_0001);
        send(32'h0000_0002);
        exp_q.push_back(32'h2222_0002);
        send(32'h2222_0002);
        send(32'h0000_0002);
        @(negedge CLK);
        check("t2_rdy_drop", 32'(RDY_requests_0_enq), 32'd0);
        check("t2_head", request_say_v, 32'h1111_0001);
        @(posedge CLK);
        #1;
        max_run = 0;
        RDY_request_say = 1'b1;
        exp_q.push_back(32'h3333_0003);
        send(32'h3333_0003);
        idle(4);
        check("t2_back_to_back", 32'(max_run), 32'd3);

        // 3: unknown method with payload is drained and counted
        send(32'h0007_0004);
        send(32'hAAAA_0001);
        send(32'hAAAA_0002);
        send(32'hAAAA_0003);
        check("t3_err", 32'(err_count), 32'd1);
        send(32'h0000_0002);
        exp_q.push_back(32'hCAFE_F00D);
        send(32'hCAFE_F00D);
        idle(3);

        // 4: header-only frame counted, following say decodes
        do_reset();
        RDY_request_say = 1'b1;
        send(32'h0000_0001);
        send(32'h0000_0002);
        exp_q.push_back(32'h1234_5678);
        send(32'h1234_5678);
        check("t4_err", 32'(err_count), 32'd1);
        idle(3);

        // 5: full buffer, pop and header accept on the same edge
        do_reset();
        RDY_request_say = 1'b0;
        send(32'h0000_0002);
        exp_q.push_back(32'h5555_0001);
        send(32'h5555_0001);
        send(32'h0000_0002);
        exp_q.push_back(32'h5555_0002);
        send(32'h5555_0002);
        @(negedge CLK);
        check("t5_rdy_idle_full", 32'(RDY_requests_0_enq), 32'd1);
        @(posedge CLK);
        #1;
        RDY_request_say = 1'b1;
        send(32'h0000_0002);
        RDY_request_say = 1'b0;
        @(negedge CLK);
        check("t5_one_left_head", request_say_v, 32'h5555_0002);
        check("t5_one_left_rdy", 32'(RDY_requests_0_enq), 32'd1);
        @(posedge CLK);
        #1;
        do_reset();
        @(negedge CLK);
        check("t5_rst_say_v", request_say_v, 32'd0);
        check("t5_rst_err", 32'(err_count), 32'd0);
        @(posedge CLK);
        #1;
        RDY_request_say = 1'b1;
        @(negedge CLK);
        check("t5_rst_empty_en", 32'(EN_request_say), 32'd0);
        @(posedge CLK);
        #1;
        send(32'h0000_0002);
        exp_q.push_back(32'h7777_0007);
        send(32'h7777_0007);
        idle(3);
        check("t5_post_rst_err", 32'(err_count), 32'd0);

        // 6: size query and counter saturation
        messageSize_size_methodNumber = 16'd0;
        #1;
        check("t6_size_say", 32'(messageSize_size), 32'd32);
        check("t6_size_rdy", 32'(RDY_messageSize_size), 32'd1);
        messageSize_size_methodNumber = 16'd5;
        #1;
        check("t6_size_other", 32'(messageSize_size), 32'd0);

        sat_v  = 32'h0005_0001;
        sat_en = 1'b1;
        idle(3);
        check("t6_sat_partial", 32'(sat_err), 32'd3);
        idle(4);
        check("t6_sat_full", 32'(sat_err), 32'd7);
        idle(3);
        check("t6_sat_hold", 32'(sat_err), 32'd7);
        sat_en = 1'b0;

        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
